// File: rtl/fifo_rd_stream_adapter_if.sv
// Handshake bundle between a fixed-latency FIFO read port, the stream adapter and its consumer.
// The master modport is the adapter's view; the slave modport is the FIFO/consumer environment's view.
interface fifo_rd_stream_adapter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_rd;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic [CNT_W-1:0]      buf_count;

  modport master (
    input  fifo_empty, fifo_data_rd, m_ready,
    output fifo_rd_en, m_valid, m_data, buf_count
  );

  modport slave (
    output fifo_empty, fifo_data_rd, m_ready,
    input  fifo_rd_en, m_valid, m_data, buf_count
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Fixed-latency FIFO read port to valid/ready stream, using a skid buffer plus in-flight credit accounting.
// Optional FIFO_RD_ADAPT_FLUSH_EN adds a flush input and a RUN/DRAIN FSM that discards buffered and in-flight data.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef FIFO_RD_ADAPT_FLUSH_EN
  input  logic flush,
`endif
  fifo_rd_stream_adapter_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int INF_W = $clog2(RD_LATENCY + 1);
  localparam int SUM_W = $clog2(BUF_DEPTH + RD_LATENCY + 1) + 1;

  logic [RD_LATENCY-1:0] pipe;
  logic [INF_W-1:0]      inflight;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [SUM_W-1:0]      demand;
  logic                  pop;
  logic                  wr;
  logic                  issue;
  logic                  run;
  logic                  clear;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + INF_W'(pipe[i]);
  end

  // Credits: entries held plus reads still returning, less the word leaving this cycle.
  assign pop    = bus.m_valid & bus.m_ready;
  assign demand = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(pop);
  assign issue  = rst_n & ~bus.fifo_empty & (demand < SUM_W'(BUF_DEPTH)) & run;
  assign wr     = pipe[RD_LATENCY-1] & run;

  assign bus.fifo_rd_en = issue;
  assign bus.m_valid    = (count != '0);
  assign bus.m_data     = mem[head];
  assign bus.buf_count  = count;

`ifdef FIFO_RD_ADAPT_FLUSH_EN
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (flush) state <= DRAIN;
        DRAIN:   if (inflight == '0 && !flush) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign run   = (state == RUN);
  assign clear = run & flush;
`else
  assign run   = 1'b1;
  assign clear = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe  <= '0;
      count <= '0;
      head  <= '0;
      tail  <= '0;
      // NOTE: the buffer is tiny and m_data must read 0 out of reset, so it is reset like any other register.
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      pipe[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];

      if (clear) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (wr) begin
          mem[tail] <= bus.fifo_data_rd;
          tail      <= ptr_inc(tail);
        end
        if (pop) head <= ptr_inc(head);
        case ({wr, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_W'(BUF_DEPTH));

endmodule
